// File: rtl/booth_mult.sv
// Sequential signed radix-4 Booth multiplier: one Booth digit per clock,
// full-width product and finish flag after OPERAND_SIZE/2 edges.
//
// state | meaning
// IDLE  | waiting for enable; start edge latches operands and retires digit 0
// BUSY  | retiring digits 1 .. OPERAND_SIZE/2-1
// DONE  | product valid, finish held high while enable stays high
module booth_mult #(
    parameter int OPERAND_SIZE = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [OPERAND_SIZE-1:0]     multiplicand,
    input  logic [OPERAND_SIZE-1:0]     multiplier,
    output logic [2*OPERAND_SIZE-1:0]   product,
    output logic                        finish
);

    localparam int N      = OPERAND_SIZE;
    localparam int DIGITS = N / 2;
    localparam int CW     = $clog2(DIGITS) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_next;

    logic [N-1:0]  a_reg;
    logic [N:0]    b_reg;      // remaining multiplier bits, bit 0 is the look-back bit
    logic [N+1:0]  hi;         // upper accumulator, N+2 bits so -2A never overflows
    logic [N-1:0]  lo;         // product bits already shifted out of the accumulator
    logic [CW-1:0] cnt;

    logic          starting, step, last;
    logic [N-1:0]  a_cur;
    logic [2:0]    digit;
    logic [N+1:0]  hi_cur, ax, pp, sum, hi_next;
    logic [N-1:0]  lo_cur, lo_next;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = BUSY;
            BUSY:    if (!enable) state_next = IDLE;
                     else if (last) state_next = DONE;
            DONE:    if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign starting = (state == IDLE) && enable;
    assign step     = ((state == IDLE) || (state == BUSY)) && enable;
    assign last     = (state == BUSY) && (cnt == CW'(DIGITS - 1));

    // On the start edge the operands come straight from the ports.
    assign a_cur  = (state == IDLE) ? multiplicand : a_reg;
    assign digit  = (state == IDLE) ? {multiplier[1:0], 1'b0} : b_reg[2:0];
    assign hi_cur = (state == IDLE) ? '0 : hi;
    assign lo_cur = (state == IDLE) ? '0 : lo;
    assign ax     = {{2{a_cur[N-1]}}, a_cur};

    always_comb begin
        pp = '0;
        case (digit)
            3'b001, 3'b010: pp = ax;
            3'b011:         pp = ax << 1;
            3'b100:         pp = -(ax << 1);
            3'b101, 3'b110: pp = -ax;
            default:        pp = '0;
        endcase
    end

    assign sum     = hi_cur + pp;
    assign hi_next = {{2{sum[N+1]}}, sum[N+1:2]};
    assign lo_next = {sum[1:0], lo_cur[N-1:2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            product <= '0;
            finish  <= 1'b0;
        end else begin
            if (starting) a_reg <= multiplicand;
            if (step) begin
                b_reg <= starting ? ({multiplier, 1'b0} >> 2) : (b_reg >> 2);
                hi    <= hi_next;
                lo    <= lo_next;
                cnt   <= starting ? CW'(1) : cnt + CW'(1);
            end
            if (last && enable) product <= {hi_next[N-1:0], lo_next};
            finish <= (state_next == DONE);
        end
    end

endmodule

// File: tb/tb_booth_mult.sv
// Self-checking bench for booth_mult (N=16): scoreboard of reference products,
// latency, hold, abort and reset behaviour.
module tb_booth_mult;
    localparam int N = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic [N-1:0]   multiplicand;
    logic [N-1:0]   multiplier;
    logic [2*N-1:0] product;
    logic           finish;

    int             checks   = 0;
    int             failures = 0;
    logic [2*N-1:0] exp_q[$];

    always #5 clk = ~clk;

    booth_mult #(.OPERAND_SIZE(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .finish       (finish)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[2*N-1:0];
    endfunction

    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        enable       = 1'b1;
        exp_q.push_back(ref_mul(a, b));
    endtask

    // Operands are scrambled after the start edge; the result must not care.
    task automatic wait_finish(input string tag);
        int edges;
        logic [2*N-1:0] e;
        edges = 0;
        while (!finish && edges < 20) begin
            @(negedge clk);
            edges++;
            if (edges == 1) begin
                multiplicand = 16'($urandom());
                multiplier   = 16'($urandom());
            end
        end
        check({tag, "_lat"}, 64'(edges), 64'(N / 2));
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else check({tag, "_sb_empty"}, 64'(0), 64'(1));
        check({tag, "_prod"}, 64'(product), 64'(e));
    endtask

    task automatic end_op(input string tag);
        logic [2*N-1:0] held;
        held = product;
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check({tag, "_fall"}, 64'(finish), 64'(0));
        check({tag, "_keep"}, 64'(product), 64'(held));
    endtask

    int da[7] = '{-72, -32768, 32767, -1, 0, 12345, -32768};
    int db[7] = '{100, -32768, -32768, -1, 12345, 0, 32767};

    initial begin
        logic [2*N-1:0] held;
        logic           rose;
        rst = 1'b1; enable = 1'b0; multiplicand = '0; multiplier = '0;
        repeat (2) @(negedge clk);
        check("rst_prod", 64'(product), 64'(0));
        check("rst_fin", 64'(finish), 64'(0));
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            start_op(16'(da[i]), 16'(db[i]));
            wait_finish($sformatf("dir%0d", i));
            end_op($sformatf("dir%0d", i));
        end

        // hold in DONE with changing operands, then restart with new ones
        start_op(16'(300), 16'(-7));
        wait_finish("hold");
        held = product;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            multiplicand = 16'($urandom());
            multiplier   = 16'($urandom());
        end
        check("hold_prod", 64'(product), 64'(held));
        check("hold_fin", 64'(finish), 64'(1));
        end_op("hold");
        start_op(16'(1000), 16'(-999));
        wait_finish("rerun");
        end_op("rerun");

        // abort by dropping enable after 3 edges
        start_op(16'(123), 16'(-456));
        repeat (3) @(negedge clk);
        held = product;
        enable = 1'b0;
        rose = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (finish) rose = 1'b1;
        end
        check("abort_fin", 64'(rose), 64'(0));
        check("abort_prod", 64'(product), 64'(held));
        void'(exp_q.pop_front());
        start_op(16'(-4321), 16'(77));
        wait_finish("post_abort");
        end_op("post_abort");

        // reset mid-BUSY
        start_op(16'(555), 16'(-3));
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_busy_fin", 64'(finish), 64'(0));
        check("rst_busy_prod", 64'(product), 64'(0));
        void'(exp_q.pop_front());
        rst = 1'b0; enable = 1'b0;
        start_op(16'(-5), 16'(7));
        wait_finish("post_rst_busy");

        // reset during DONE
        rst = 1'b1;
        @(negedge clk);
        check("rst_done_fin", 64'(finish), 64'(0));
        check("rst_done_prod", 64'(product), 64'(0));
        rst = 1'b0; enable = 1'b0;
        start_op(16'(-32768), 16'(-32768));
        wait_finish("post_rst_done");
        end_op("post_rst_done");

        for (int i = 0; i < 20; i++) begin
            start_op(16'($urandom()), 16'($urandom()));
            wait_finish($sformatf("rnd%0d", i));
            end_op($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
